// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the router input channels, the output
// allocator and the crossbar.
interface switch_allocator_if #(
  parameter int NUM_PORTS = 5,
  parameter int BITS_DIR  = 3
);
  logic [NUM_PORTS-1:0]          req_valid;
  logic [NUM_PORTS*BITS_DIR-1:0] req_dir;
  logic [NUM_PORTS-1:0]          req_last;
  logic [NUM_PORTS-1:0]          out_busy;
  logic [NUM_PORTS-1:0]          grant;
  logic [NUM_PORTS-1:0]          out_valid;
  logic [NUM_PORTS*BITS_DIR-1:0] xbar_sel;
  logic                          active;
  logic                          alloc_err;

  modport master (
    output req_valid, req_dir, req_last, out_busy,
    input  grant, out_valid, xbar_sel, active, alloc_err
  );

  modport slave (
    input  req_valid, req_dir, req_last, out_busy,
    output grant, out_valid, xbar_sel, active, alloc_err
  );
endinterface

// File: rtl/switch_allocator.sv
// Per-output packet-long allocator: each output locks to one input chosen
// round-robin, then streams that input's flits until the tail.
module switch_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int BITS_DIR  = 3
) (
  input logic              clk,
  input logic              reset,
  switch_allocator_if.slave bus
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state    [NUM_PORTS];
  state_t              state_nx [NUM_PORTS];
  logic [BITS_DIR-1:0] owner    [NUM_PORTS];
  logic [BITS_DIR-1:0] owner_nx [NUM_PORTS];
  logic [BITS_DIR-1:0] ptr      [NUM_PORTS];
  logic [BITS_DIR-1:0] ptr_nx   [NUM_PORTS];
  logic [BITS_DIR-1:0] dir      [NUM_PORTS];
  logic [NUM_PORTS-1:0] bound;
  logic [NUM_PORTS-1:0] grant_c;
  logic [NUM_PORTS-1:0] out_valid_c;
  logic [NUM_PORTS*BITS_DIR-1:0] sel_flat;
  logic err_hit;
  logic active_nx;
  logic active_r;
  logic err_r;

  always_comb begin
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      dir[k] = bus.req_dir[k*BITS_DIR +: BITS_DIR];
    end
  end

  // An input is bound while any output is locked to it.
  always_comb begin
    bound = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (state[o] == LOCKED && 32'(owner[o]) == k) bound[k] = 1'b1;
      end
    end
  end

  always_comb begin : alloc_comb
    int unsigned cand;
    logic        found;
    state_nx    = state;
    owner_nx    = owner;
    ptr_nx      = ptr;
    grant_c     = '0;
    out_valid_c = '0;
    err_hit     = 1'b0;
    active_nx   = 1'b0;
    cand        = 0;
    found       = 1'b0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      if (state[o] == LOCKED) begin
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
          if (32'(owner[o]) == k) begin
            out_valid_c[o] = bus.req_valid[k] & ~bus.out_busy[o];
            grant_c[k]     = grant_c[k] | out_valid_c[o];
            if (out_valid_c[o] && bus.req_last[k]) begin
              state_nx[o] = IDLE;
              ptr_nx[o]   = owner[o];
            end
          end
        end
      end else begin
        // Scan starts one past the last releasing owner.
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
          cand = (32'(ptr[o]) + i) % NUM_PORTS;
          if (!found && bus.req_valid[cand] && !bound[cand] &&
              dir[cand] == BITS_DIR'(o)) begin
            found       = 1'b1;
            owner_nx[o] = BITS_DIR'(cand);
            state_nx[o] = LOCKED;
          end
        end
      end
      if (state_nx[o] == LOCKED) active_nx = 1'b1;
    end
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (bus.req_valid[k] && !bound[k] && 32'(dir[k]) >= NUM_PORTS) err_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        ptr[o]   <= BITS_DIR'(NUM_PORTS - 1);
      end
      active_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      ptr      <= ptr_nx;
      active_r <= active_nx;
      err_r    <= err_r | err_hit;
    end
  end

  always_comb begin
    sel_flat = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      sel_flat[o*BITS_DIR +: BITS_DIR] = owner[o];
    end
  end

  assign bus.grant     = grant_c;
  assign bus.out_valid = out_valid_c;
  assign bus.xbar_sel  = sel_flat;
  assign bus.active    = active_r;
  assign bus.alloc_err = err_r;
endmodule
